// File: rtl/fetch_buffer.sv
// Circular fetch FIFO between the I$/bus fetch path and the spill/merge stage.
// Outputs are decoded from registered state only; full raises FetchBufferStallF.
module fetch_buffer #(
    parameter int              XLEN  = 64,
    parameter int              DEPTH = 3,
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP  = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       FlushD,
    input  logic                       StallD,
    input  logic                       WriteValidF,
    input  logic [WIDTH-1:0]           WriteDataF,
    input  logic [XLEN-1:0]            WritePCF,
    output logic [WIDTH-1:0]           ReadDataF,
    output logic [XLEN-1:0]            ReadPCF,
    output logic                       ReadValidF,
    output logic                       FetchBufferStallF,
    output logic [$clog2(DEPTH+1)-1:0] CountF
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic          w_full;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = WriteValidF & ~w_full & ~FlushD;
    assign w_pop   = w_valid & ~StallD & ~FlushD;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (FlushD) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)
                r_head <= w_head_nxt;
            if (w_push)
                r_tail <= w_tail_nxt;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_tail] <= WriteDataF;
            r_pc[r_tail]   <= WritePCF;
        end
    end

    always_comb begin
        ReadValidF        = w_valid;
        FetchBufferStallF = w_full;
        CountF            = r_count;
        ReadDataF         = NOP;
        ReadPCF           = '0;
        if (w_valid) begin
            ReadDataF = r_data[r_head];
            ReadPCF   = r_pc[r_head];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        r_count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_pop && r_count == '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && w_full));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model checked
// every negedge, plus directed scenarios with literal expectations.
module tb_fetch_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 3;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] NOP = 32'h00000013;

    logic             clk;
    logic             reset;
    logic             FlushD;
    logic             StallD;
    logic             WriteValidF;
    logic [WIDTH-1:0] WriteDataF;
    logic [XLEN-1:0]  WritePCF;
    logic [WIDTH-1:0] ReadDataF;
    logic [XLEN-1:0]  ReadPCF;
    logic             ReadValidF;
    logic             FetchBufferStallF;
    logic [CW-1:0]    CountF;

    fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .WIDTH(WIDTH), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .FlushD(FlushD), .StallD(StallD),
        .WriteValidF(WriteValidF), .WriteDataF(WriteDataF), .WritePCF(WritePCF),
        .ReadDataF(ReadDataF), .ReadPCF(ReadPCF), .ReadValidF(ReadValidF),
        .FetchBufferStallF(FetchBufferStallF), .CountF(CountF)
    );

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {pc, word} with capacity DEPTH.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            bit   do_push;
            bit   do_pop;
            ent_t e;
            do_push = WriteValidF && (q.size() < DEPTH) && !FlushD;
            do_pop  = (q.size() != 0) && !StallD && !FlushD;
            if (FlushD) begin
                q.delete();
            end else begin
                if (do_pop)
                    void'(q.pop_front());
                if (do_push) begin
                    e.pc = WritePCF;
                    e.d  = WriteDataF;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic [XLEN-1:0]  ep;
        ev = (q.size() != 0);
        ed = ev ? q[0].d  : NOP;
        ep = ev ? q[0].pc : '0;
        check("model_valid", 64'(ReadValidF), 64'(ev));
        check("model_data",  64'(ReadDataF),  64'(ed));
        check("model_pc",    64'(ReadPCF),    64'(ep));
        check("model_count", 64'(CountF),     64'(q.size()));
        check("model_stall", 64'(FetchBufferStallF), 64'(q.size() == DEPTH));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [WIDTH-1:0] d, input logic [XLEN-1:0] pc);
        WriteValidF = v;
        WriteDataF  = d;
        WritePCF    = pc;
    endtask

    task automatic check_empty(input string name);
        check({name, "_valid"}, 64'(ReadValidF), 64'd0);
        check({name, "_data"},  64'(ReadDataF),  64'(NOP));
        check({name, "_pc"},    64'(ReadPCF),    64'd0);
        check({name, "_count"}, 64'(CountF),     64'd0);
        check({name, "_stall"}, 64'(FetchBufferStallF), 64'd0);
    endtask

    task automatic single_push(input string name);
        StallD = 1'b0;
        put(1'b1, 32'h00A00093, 64'h80000000);
        step();
        put(1'b0, '0, '0);
        check({name, "_valid"}, 64'(ReadValidF), 64'd1);
        check({name, "_data"},  64'(ReadDataF),  64'h00A00093);
        check({name, "_pc"},    64'(ReadPCF),    64'h80000000);
        step();
        check_empty({name, "_after"});
    endtask

    localparam logic [WIDTH-1:0] WA = 32'h11111111, WB = 32'h22222222;
    localparam logic [WIDTH-1:0] WC = 32'h33333333, WD = 32'h44444444;

    initial begin
        reset = 1'b0; FlushD = 1'b0; StallD = 1'b0;
        put(1'b0, '0, '0);
        #12 reset = 1'b1;
        step();
        check_empty("reset");

        single_push("s1");

        // Fill while stalled; a fourth word must be refused.
        StallD = 1'b1;
        put(1'b1, WA, 64'h100); step();
        put(1'b1, WB, 64'h104); step();
        put(1'b1, WC, 64'h108); step();
        check("s2_count", 64'(CountF), 64'd3);
        check("s2_stall", 64'(FetchBufferStallF), 64'd1);
        put(1'b1, WD, 64'h10C); step();
        check("s2_count_held", 64'(CountF), 64'd3);
        put(1'b0, '0, '0);
        StallD = 1'b0;
        check("s2_out_a", 64'(ReadDataF), 64'(WA));
        step();
        check("s2_out_b", 64'(ReadDataF), 64'(WB));
        step();
        check("s2_out_c", 64'(ReadDataF), 64'(WC));
        check("s2_pc_c",  64'(ReadPCF),   64'h108);
        step();
        check_empty("s2_end");

        // Full, pop and write together: pop wins, write dropped.
        StallD = 1'b1;
        put(1'b1, WA, 64'h200); step();
        put(1'b1, WB, 64'h204); step();
        put(1'b1, WC, 64'h208); step();
        StallD = 1'b0;
        put(1'b1, WD, 64'h20C); step();
        check("s3_count", 64'(CountF), 64'd2);
        check("s3_stall", 64'(FetchBufferStallF), 64'd0);
        check("s3_head",  64'(ReadDataF), 64'(WB));
        StallD = 1'b1;
        step();
        check("s3_retry_count", 64'(CountF), 64'd3);
        put(1'b0, '0, '0);
        StallD = 1'b0;
        step();
        check("s3_out_c", 64'(ReadDataF), 64'(WC));
        step();
        check("s3_out_d", 64'(ReadDataF), 64'(WD));
        check("s3_pc_d",  64'(ReadPCF),   64'h20C);
        step();
        check_empty("s3_end");

        // Streaming: one push per cycle, each word visible one cycle later.
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 32'hC0DE0000 + 32'(i), 64'h1000 + 64'(4 * i));
            step();
            check("s4_data",  64'(ReadDataF), 64'(32'hC0DE0000 + 32'(i)));
            check("s4_count", 64'(CountF), 64'd1);
        end
        put(1'b0, '0, '0);
        step();
        check_empty("s4_end");

        // Flush with a same-cycle write.
        StallD = 1'b1;
        put(1'b1, WA, 64'h300); step();
        put(1'b1, WB, 64'h304); step();
        FlushD = 1'b1;
        put(1'b1, 32'hDEADBEEF, 64'h308); step();
        FlushD = 1'b0;
        put(1'b0, '0, '0);
        StallD = 1'b0;
        check_empty("s5_flush");
        step();
        check_empty("s5_after");

        // Asynchronous reset between edges.
        StallD = 1'b1;
        put(1'b1, WA, 64'h400); step();
        put(1'b1, WB, 64'h404); step();
        put(1'b0, '0, '0);
        #2 reset = 1'b0;
        #1 check_empty("s6_async");
        #3 reset = 1'b1;
        single_push("s6_push");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            put($urandom_range(99) < 60, $urandom, {$urandom, $urandom});
            StallD = ($urandom_range(99) < 35);
            FlushD = ($urandom_range(99) < 4);
            step();
        end
        FlushD = 1'b0; StallD = 1'b0;
        put(1'b0, '0, '0);
        step();
        step();
        check_empty("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
